rate_xfer: RTL

Parametrised single-clock rate-transfer block, the successor to the 12-bit fast-to-slow sample crossing. It samples a multi-channel data bus on `fast_clk` and synchronises a free-running `slow_clk` tick input with a configurable synchronizer depth. On each `slow_clk` rising edge it captures one multi-channel frame into a first-word-fall-through FIFO. Downstream slow-rate logic (modulator, DAC feeder) drains frames with a valid/ready handshake.

---
 rtl/rate_xfer_pkg.sv | 14 +
 rtl/rate_xfer_sync.sv | 24 ++
 rtl/rate_xfer.sv | 83 ++++++++
 3 files changed

// File: rtl/rate_xfer_pkg.sv
// rate_xfer_pkg: shared constants and helpers for rate_xfer (optional overflow flag via RATE_XFER_OVF_EN)
package rate_xfer_pkg;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    function automatic int frame_bits(input int width, input int channels);
        return width * channels;
    endfunction

    function automatic bit params_ok(input int width, input int channels, input int sync, input int depth);
        return width > 0 && channels > 0 && sync >= SYNC_MIN && sync <= SYNC_MAX &&
               depth >= 2 && (depth & (depth - 1)) == 0;
    endfunction
endpackage

// File: rtl/rate_xfer_sync.sv
// rate_xfer_sync: slow_clk synchronizer chain plus history flop, one-cycle tick per rising edge
module rate_xfer_sync #(
    parameter int STAGES = 2
) (
    input  logic fast_clk,
    input  logic reset,
    input  logic slow_clk,
    output logic tick
);
    logic [STAGES-1:0] sync;
    logic              hist;

    always_ff @(posedge fast_clk) begin
        if (reset) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], slow_clk};
            hist <= sync[STAGES-1];
        end
    end

    assign tick = sync[STAGES-1] & ~hist;
endmodule

// File: rtl/rate_xfer.sv
// rate_xfer: slow_clk-ticked frame capture into a FWFT FIFO; RATE_XFER_OVF_EN adds a sticky overflow port
module rate_xfer
    import rate_xfer_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int CHANNELS    = 1,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                         fast_clk,
    input  logic                         reset,
    input  logic                         slow_clk,
    input  logic [CHANNELS*WIDTH-1:0]    data,
    output logic [CHANNELS*WIDTH-1:0]    d,
    output logic                         d_valid,
    input  logic                         d_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef RATE_XFER_OVF_EN
    ,
    output logic                         overflow
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef logic [frame_bits(WIDTH, CHANNELS)-1:0] frame_t;

    if (!params_ok(WIDTH, CHANNELS, SYNC_STAGES, DEPTH)) begin : g_bad_params
        $error("rate_xfer: illegal parameter set");
    end

    frame_t          mem [DEPTH];
    frame_t          data_q;
    frame_t          last;
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic            tick;
    logic            full;
    logic            pop;
    logic            push;

    rate_xfer_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .fast_clk (fast_clk),
        .reset    (reset),
        .slow_clk (slow_clk),
        .tick     (tick)
    );

    assign full    = level == LW'(DEPTH);
    assign d_valid = level != '0;
    assign pop     = d_valid & d_ready;
    assign push    = tick & (~full | pop);
    assign d       = d_valid ? mem[rp] : last;

    always_ff @(posedge fast_clk) begin
        if (push) mem[wp] <= data_q;
    end

    always_ff @(posedge fast_clk) begin
        if (reset) begin
            data_q <= '0;
            last   <= '0;
            wp     <= '0;
            rp     <= '0;
            level  <= '0;
        end else begin
            data_q <= data;
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp   <= rp + 1'b1;
                last <= mem[rp];
            end
            level <= level + LW'(push) - LW'(pop);
        end
    end

`ifdef RATE_XFER_OVF_EN
    always_ff @(posedge fast_clk) begin
        if (reset) overflow <= 1'b0;
        else if (tick & full & ~pop) overflow <= 1'b1;
    end
`endif
endmodule
